mux8_skid_reg: RTL
==================

Name: mux8_skid_reg

Overview:
- Registered, back-pressurable pipeline stage directly downstream of the mux8 result selector in the MCU datapath.
- Captures the selected 64-bit mux output, and the 3-bit select used to pick it, with a valid/ready handshake.
- Two-entry skid buffer: full throughput with both in_ready and out_valid registered. No combinational path from out_ready to in_ready.
- Carries a wrapping output-transfer counter for debug and performance visibility.

Parameters:
- DATA_WIDTH, 64, width of in_data/out_data; must match the upstream mux8 DATA_WIDTH.
- TAG_WIDTH, 3, width of in_tag/out_tag; carries the mux8 sel value.
- CNT_WIDTH, 32, width of xfer_count.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards all held entries.
- in_valid  input  1  upstream has a beat.
- in_ready  output  1  stage can accept a beat; registered.
- in_data  input  DATA_WIDTH  mux8 out.
- in_tag  input  TAG_WIDTH  mux8 sel that produced in_data.
- out_valid  output  1  out_data/out_tag hold a beat; registered.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_WIDTH  registered data.
- out_tag  output  TAG_WIDTH  registered tag.
- xfer_count  output  CNT_WIDTH  number of completed output handshakes, modulo 2^CNT_WIDTH.

Behaviour:
- Storage: main register (drives out_*) and skid register. State is EMPTY, ONE or FULL.
- Outputs: out_valid = (state != EMPTY); in_ready = (state != FULL). Both decoded from state flops only.
- Handshakes: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready. Each is sampled at the rising edge.
- EMPTY:
  - input transfer: data to main, go to ONE.
  - otherwise stay.
- ONE:
  - input and output transfer together: main <= input, stay in ONE.
  - output transfer only: go to EMPTY.
  - input transfer only: data to skid, go to FULL.
  - neither: hold.
- FULL (in_ready=0):
  - output transfer: main <= skid, go to ONE.
  - otherwise hold.
- Latency: a beat accepted at edge N while EMPTY gives out_valid=1 with that data from edge N to N+1. Sustained throughput is 1 beat/cycle when out_ready stays high.
- Ordering: strict FIFO. Beats are never reordered, duplicated or dropped, except by flush or reset.
- Stability: while out_valid=1 and out_ready=0, out_data and out_tag are held unchanged.
- xfer_count increments by 1 on every output transfer and wraps from all-ones to 0. It is not cleared by flush.
- Flush (has priority over handshakes): at the edge where flush=1, state goes to EMPTY.
  - Any input offered in that cycle is discarded.
  - An output handshake in that cycle still counts in xfer_count.
  - out_valid=0 and in_ready=1 from the next cycle. Data registers keep their values.
- Reset (priority over flush): at the edge where rst=1, state goes to EMPTY; main, skid, out_data, out_tag and xfer_count go to 0.
  - out_valid=0 and in_ready=1 after reset.
  - While rst=1, no transfers are recorded and in_valid is ignored.
  - Reset mid-FULL drops both entries.
- X handling: in_data/in_tag are don't-care when in_valid=0 and are never captured in that case.

Test Plan:
- Reset then single beat: rst 1 cycle, then in_valid=1, in_data=0x1, in_tag=3'b001, out_ready=1 -> next cycle out_valid=1, out_data=0x1, out_tag=1; following cycle out_valid=0; xfer_count=1.
- Streaming: beats 0x0..0x7 with tags 0..7 on consecutive cycles, out_ready=1 -> out_data 0x0..0x7 on consecutive cycles, one cycle delayed; in_ready stays 1; xfer_count=8.
- Back-pressure: out_ready=0, send 0x5, 0x6, 0x7 -> in_ready drops after 0x6 (FULL), 0x7 held upstream; out_data stays 0x5. Raise out_ready -> outputs 0x5, 0x6, 0x7 in order, none lost.
- Simultaneous in/out in ONE: holding 0x2; in_valid=1 with 0x3 and out_ready=1 on the same edge -> state stays ONE, out_data=0x3, in_ready=1 throughout.
- Flush when FULL: entries 0x4, 0x5 held; flush=1 with in_valid=1 and 0x6 -> next cycle out_valid=0, in_ready=1; 0x6 never appears; xfer_count unchanged.
- Counter wrap and reset: CNT_WIDTH=4, 17 transfers -> xfer_count=1. rst while FULL -> out_valid=0, out_data=0, xfer_count=0 next cycle.

Source files
------------

// File: rtl/mux8_skid_reg.sv
// -----------------------------------------------------------------------------
// mux8_skid_reg
//
// Registered, back-pressurable pipeline stage that sits directly after the
// mux8 result selector. It captures the selected data word together with the
// select value that produced it, and passes both downstream under a
// valid/ready handshake.
//
// The stage is a two-entry skid buffer:
//   - main register : drives out_data / out_tag
//   - skid register : catches the beat that arrives in the same cycle the
//                     downstream first stalls
// With two entries the stage sustains one beat per cycle while both in_ready
// and out_valid come straight from state flops, so out_ready never reaches
// in_ready through logic.
//
// A wrapping counter of completed output handshakes is provided for debug and
// performance visibility. Flush does not clear it; reset does.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst        : synchronous active-high reset (priority over flush)
//   flush      : synchronous flush, drops held entries (priority over handshakes)
//   in_valid   : upstream presents a beat
//   in_ready   : stage can accept a beat (decoded from state flops)
//   in_data    : mux8 output word
//   in_tag     : mux8 select that produced in_data
//   out_valid  : out_data/out_tag hold a beat (decoded from state flops)
//   out_ready  : downstream accepts the beat
//   out_data   : registered data
//   out_tag    : registered tag
//   xfer_count : completed output handshakes, modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module mux8_skid_reg #(
   parameter int DATA_WIDTH = 64,
   parameter int TAG_WIDTH  = 3,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic [CNT_WIDTH-1:0]  xfer_count
);

   // One beat as it travels through the stage: the select rides with its data.
   typedef struct packed {
      logic [TAG_WIDTH-1:0]  tag;
      logic [DATA_WIDTH-1:0] data;
   } beat_t;

   // Number of held entries: none, main only, main + skid.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t               state;
   beat_t                main_q;
   beat_t                skid_q;
   beat_t                in_beat;
   logic                 in_xfer;
   logic                 out_xfer;
   logic [CNT_WIDTH-1:0] cnt_q;

   assign in_beat  = {in_tag, in_data};

   // Both handshake qualifiers come from state, never from the other side's
   // handshake input, which keeps the two ports timing-isolated.
   assign out_valid = (state != S_EMPTY);
   assign in_ready  = (state != S_FULL);

   assign in_xfer  = in_valid  & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_EMPTY;
         main_q <= '0;
         skid_q <= '0;
         cnt_q  <= '0;
      end else begin
         // A handshake completed in a flush cycle was really seen downstream,
         // so it is still counted.
         if (out_xfer)
            cnt_q <= cnt_q + CNT_ONE;

         if (flush) begin
            // Data registers keep their contents; only occupancy is dropped.
            state <= S_EMPTY;
         end else begin
            unique case (state)
               S_EMPTY: begin
                  if (in_xfer) begin
                     main_q <= in_beat;
                     state  <= S_ONE;
                  end
               end

               S_ONE: begin
                  if (in_xfer && out_xfer) begin
                     // Old beat leaves, new beat takes its place.
                     main_q <= in_beat;
                  end else if (out_xfer) begin
                     state  <= S_EMPTY;
                  end else if (in_xfer) begin
                     // Downstream stalled while a beat was already in flight
                     // toward us: park it behind the main entry.
                     skid_q <= in_beat;
                     state  <= S_FULL;
                  end
               end

               S_FULL: begin
                  // in_ready is low here, so only the output side can move.
                  if (out_xfer) begin
                     main_q <= skid_q;
                     state  <= S_ONE;
                  end
               end

               default: state <= S_EMPTY;
            endcase
         end
      end
   end

   assign out_data   = main_q.data;
   assign out_tag    = main_q.tag;
   assign xfer_count = cnt_q;

endmodule
